// File: rtl/pc_unit.sv
// Program-counter unit: write-controlled PC with next-PC selection among
// sequential, branch, jump and return sources, backed by a circular return-address stack.
module pc_unit #(
    parameter int unsigned     WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(1),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pc_write,
    input  logic                             pc_write_cond,
    input  logic                             zero,
    input  logic [1:0]                       pc_src,
    input  logic [WIDTH-1:0]                 branch_target,
    input  logic [WIDTH-1:0]                 jump_target,
    input  logic                             call,
    output logic [WIDTH-1:0]                 pc,
    output logic [WIDTH-1:0]                 pc_plus,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow,
    output logic                             redirect
);

    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        SrcSeq    = 2'b00,
        SrcBranch = 2'b01,
        SrcJump   = 2'b10,
        SrcReturn = 2'b11
    } pc_src_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  wp_q, wp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             redirect_q, redirect_d;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic             take;
    logic             push;
    logic             pop_req;
    logic             ras_empty;
    logic             ras_full;
    logic [PtrW-1:0]  top_idx;

    assign take      = pc_write | (pc_write_cond & zero);
    assign push      = take & (pc_src_e'(pc_src) == SrcJump) & call;
    assign pop_req   = take & (pc_src_e'(pc_src) == SrcReturn);
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CntW'(RAS_DEPTH));
    assign top_idx   = wp_q - PtrW'(1);
    assign pc_plus   = pc_q + STEP;

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        wp_d       = wp_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        redirect_d = 1'b0;
        if (take) begin
            unique case (pc_src_e'(pc_src))
                SrcSeq: pc_d = pc_plus;
                SrcBranch: begin
                    pc_d       = branch_target;
                    redirect_d = 1'b1;
                end
                SrcJump: begin
                    pc_d       = jump_target;
                    redirect_d = 1'b1;
                    if (call) begin
                        wp_d = wp_q + PtrW'(1);
                        // A full stack drops its oldest entry: the write simply laps it.
                        if (ras_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CntW'(1);
                        end
                    end
                end
                SrcReturn: begin
                    if (ras_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d       = ras_mem[top_idx];
                        wp_d       = top_idx;
                        count_d    = count_q - CntW'(1);
                        redirect_d = 1'b1;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            count_q    <= '0;
            wp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            wp_q       <= wp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            redirect_q <= redirect_d;
        end
    end

    // Stack storage is left uninitialised by reset; count/wp make stale data unreachable.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[wp_q] <= pc_plus;
        end
    end

    logic unused_pop;
    assign unused_pop = pop_req;

    assign pc            = pc_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign redirect      = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every cycle,
// plus hand-computed checkpoints along a directed sequence.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        zero;
    logic [1:0]  pc_src;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic        call;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        redirect;

    pc_unit #(
        .WIDTH       (16),
        .RESET_VECTOR(16'h0100),
        .STEP        (16'h0001),
        .RAS_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .zero         (zero),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .call         (call),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow),
        .redirect     (redirect)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stack is a queue of return addresses, newest at the back.
    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_red;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc    = 16'h0100;
            m_ras.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_red   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_red = 1'b0;
            if (pc_write || (pc_write_cond && zero)) begin
                case (pc_src)
                    2'd0: m_pc = m_pc + 16'd1;
                    2'd1: begin m_pc = branch_target; m_red = 1'b1; end
                    2'd2: begin
                        if (call) begin
                            if (m_ras.size() == 4) begin
                                void'(m_ras.pop_front());
                                m_ovf = 1'b1;
                            end
                            m_ras.push_back(m_pc + 16'd1);
                        end
                        m_pc  = jump_target;
                        m_red = 1'b1;
                    end
                    default: begin
                        if (m_ras.size() == 0) begin
                            m_unf = 1'b1;
                        end else begin
                            m_pc  = m_ras.pop_back();
                            m_red = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Literal checkpoints: requested by the stimulus process, checked by the compare process.
    int          lit_req = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [15:0] lit_pc;
    logic [2:0]  lit_cnt;
    logic        lit_red, lit_ovf, lit_unf;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("pc", pc, m_pc);
            cmp("pc_plus", pc_plus, m_pc + 16'd1);
            cmp("ras_count", {13'd0, ras_count}, 16'(m_ras.size()));
            cmp("ras_overflow", {15'd0, ras_overflow}, {15'd0, m_ovf});
            cmp("ras_underflow", {15'd0, ras_underflow}, {15'd0, m_unf});
            cmp("redirect", {15'd0, redirect}, {15'd0, m_red});
        end
        if (lit_req != lit_done) begin
            cmp({lit_name, ".pc"}, pc, lit_pc);
            cmp({lit_name, ".count"}, {13'd0, ras_count}, {13'd0, lit_cnt});
            cmp({lit_name, ".redirect"}, {15'd0, redirect}, {15'd0, lit_red});
            cmp({lit_name, ".ovf"}, {15'd0, ras_overflow}, {15'd0, lit_ovf});
            cmp({lit_name, ".unf"}, {15'd0, ras_underflow}, {15'd0, lit_unf});
            lit_done = lit_req;
        end
    end

    task automatic expect_lit(input string name, input logic [15:0] p, input logic [2:0] c,
                              input logic r, input logic o, input logic u);
        lit_name = name;
        lit_pc   = p;
        lit_cnt  = c;
        lit_red  = r;
        lit_ovf  = o;
        lit_unf  = u;
        lit_req++;
    endtask

    task automatic step(input logic rst, input logic pw, input logic pwc, input logic z,
                        input logic [1:0] src, input logic [15:0] bt, input logic [15:0] jt,
                        input logic cl);
        @(negedge clk);
        reset         = rst;
        pc_write      = pw;
        pc_write_cond = pwc;
        zero          = z;
        pc_src        = src;
        branch_target = bt;
        jump_target   = jt;
        call          = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    endtask
    task automatic seq();
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    endtask
    task automatic jump(input logic [15:0] t, input logic cl);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0, t, cl);
    endtask
    task automatic ret();
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
        pc_src = 2'd0; branch_target = '0; jump_target = '0; call = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        expect_lit("reset", 16'h0100, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (pc_plus !== 16'h0101) begin
            n_bad++;
            $display("FAIL reset.pc_plus: got %h expected 0101", pc_plus);
        end
        repeat (3) idle();
        expect_lit("hold", 16'h0100, 3'd0, 1'b0, 1'b0, 1'b0);

        jump(16'h0000, 1'b0);
        expect_lit("jump0", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) seq();
        expect_lit("seq3", 16'h0003, 3'd0, 1'b0, 1'b0, 1'b0);
        jump(16'hFFFF, 1'b0);
        seq();
        expect_lit("wrap", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0040, 16'h0, 1'b0);
        expect_lit("br_nz", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0040, 16'h0, 1'b0);
        expect_lit("br_z", 16'h0040, 3'd0, 1'b1, 1'b0, 1'b0);
        idle();
        expect_lit("br_after", 16'h0040, 3'd0, 1'b0, 1'b0, 1'b0);

        jump(16'h0010, 1'b0);
        jump(16'h0200, 1'b1);
        expect_lit("call", 16'h0200, 3'd1, 1'b1, 1'b0, 1'b0);
        idle();
        ret();
        expect_lit("return", 16'h0011, 3'd0, 1'b1, 1'b0, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            jump(16'(i * 16), 1'b0);
            jump(16'h0300, 1'b1);
        end
        expect_lit("nest5", 16'h0300, 3'd4, 1'b1, 1'b1, 1'b0);
        ret();
        expect_lit("pop1", 16'h0051, 3'd3, 1'b1, 1'b1, 1'b0);
        ret();
        expect_lit("pop2", 16'h0041, 3'd2, 1'b1, 1'b1, 1'b0);
        ret();
        expect_lit("pop3", 16'h0031, 3'd1, 1'b1, 1'b1, 1'b0);
        ret();
        expect_lit("pop4", 16'h0021, 3'd0, 1'b1, 1'b1, 1'b0);
        ret();
        expect_lit("pop_empty", 16'h0021, 3'd0, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        expect_lit("both_en", 16'h0022, 3'd0, 1'b0, 1'b1, 1'b1);
        // call ignored with sequential source
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0700, 1'b1);
        expect_lit("call_ign", 16'h0023, 3'd0, 1'b0, 1'b1, 1'b1);
        jump(16'h0500, 1'b1);
        ret();
        expect_lit("push_pop", 16'h0024, 3'd0, 1'b1, 1'b1, 1'b1);

        jump(16'h0600, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0, 16'h0800, 1'b1);
        expect_lit("rst_call", 16'h0100, 3'd0, 1'b0, 1'b0, 1'b0);
        ret();
        expect_lit("rst_empty", 16'h0100, 3'd0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
